// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and
// line idle level. Used by the transmitter and later by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS            = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 580;
    localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud timing: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A restart strobe realigns the count to 0 so a frame's start bit gets its
// full length. bit_end decodes the registered count, so it is high for
// exactly one cycle per bit.
import uart_pkg::*;

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic bit_end
);

    localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

    logic [9:0] cnt;

    // Bit-period counter; wraps at the end of each bit or on restart.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/transmitter.sv
// UART transmitter: 4-phase req/ack byte intake, idle-high serial frame
// (start, 8 data bits LSB first, optional even parity, stop).
// Optional parity bit: define TX_PARITY_EN.
//
//   state  | meaning
//   IDLE   | line at mark, waiting for req with ack low
//   START  | driving the start bit (0)
//   DATA   | driving data bits, LSB first
//   PARITY | driving even parity of the byte (TX_PARITY_EN only)
//   STOP   | driving the stop bit (1)
import uart_pkg::*;

module transmitter #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       txd,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t  state, state_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic       txd_nxt, ack_nxt, busy_nxt;
    logic       restart, bit_end;
`ifdef TX_PARITY_EN
    logic       par_q, par_nxt;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .bit_end (bit_end)
    );

    // State and all outputs are registered; clr forces the line to mark at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            txd       <= IDLE_LEVEL;
            ack       <= 1'b0;
            busy      <= 1'b0;
`ifdef TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            txd       <= txd_nxt;
            ack       <= ack_nxt;
            busy      <= busy_nxt;
`ifdef TX_PARITY_EN
            par_q     <= par_nxt;
`endif
        end
    end

    // Next-state, frame sequencing and handshake logic.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        txd_nxt     = txd;
        ack_nxt     = ack;
        restart     = 1'b0;
`ifdef TX_PARITY_EN
        par_nxt     = par_q;
`endif

        // Handshake release is independent of where the frame is.
        if (ack && !req) begin
            ack_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (req && !ack) begin
                    shift_nxt   = data;
                    ack_nxt     = 1'b1;
                    state_nxt   = START;
                    txd_nxt     = ~IDLE_LEVEL;
                    bit_idx_nxt = '0;
                    restart     = 1'b1;
`ifdef TX_PARITY_EN
                    par_nxt     = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    txd_nxt     = shift_reg[0];
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_nxt = '0;
`ifdef TX_PARITY_EN
                        state_nxt   = PARITY;
                        txd_nxt     = par_q;
`else
                        state_nxt   = STOP;
                        txd_nxt     = IDLE_LEVEL;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        txd_nxt     = shift_reg[1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    txd_nxt   = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    txd_nxt   = IDLE_LEVEL;
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = IDLE_LEVEL;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter with a 4-cycle bit period.
// A frame-level model predicts txd/busy/ack every cycle; a line decoder
// recovers bytes from txd and the results are pinned with literals.
module tb_transmitter;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       req;
    logic [7:0] data;
    logic       ack, txd, busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .clr  (clr),
        .req  (req),
        .data (data),
        .ack  (ack),
        .txd  (txd),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic        m_busy, m_ack, m_ack_prev;
    int          m_el;
    logic [10:0] m_bits;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_busy = 1'b0;
            m_ack  = 1'b0;
            m_el   = 0;
        end else begin
            m_ack_prev = m_ack;
            if (m_ack && !req) m_ack = 1'b0;
            if (m_busy) begin
                m_el++;
                if (m_el == NBITS * CPB) m_busy = 1'b0;
            end else if (req && !m_ack_prev) begin
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = data[i];
`ifdef TX_PARITY_EN
                m_bits[9] = ^data;
`else
                m_bits[9] = 1'b1;
`endif
                m_bits[10] = 1'b1;
                m_busy = 1'b1;
                m_ack  = 1'b1;
                m_el   = 0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("model_txd", txd, m_busy ? m_bits[m_el / CPB] : 1'b1);
        chk("model_busy", busy, m_busy);
        chk("model_ack", ack, m_ack);
    end

    // ---------------- line decoder ----------------
    logic       d_in, d_prev;
    int         d_pos;
    logic [7:0] d_sh;
    logic       d_par;
    logic [7:0] rx_q[$];
    logic       par_q[$];

    always @(negedge clk or posedge clr) begin
        if (clr) begin
            d_in   = 1'b0;
            d_prev = 1'b1;
            d_pos  = 0;
        end else begin
            if (!d_in) begin
                if (d_prev && !txd) begin
                    d_in  = 1'b1;
                    d_pos = 0;
                    d_sh  = '0;
                end
            end else begin
                d_pos++;
                if ((d_pos % CPB) == 2) begin
                    int k;
                    k = d_pos / CPB;
                    if (k >= 1 && k <= 8) d_sh[k-1] = txd;
                    if (NBITS == 11 && k == 9) d_par = txd;
                    if (k == NBITS - 1) begin
                        chk("stop_bit", txd, 1'b1);
                        rx_q.push_back(d_sh);
                        if (NBITS == 11) par_q.push_back(d_par);
                        d_in = 1'b0;
                    end
                end
            end
            d_prev = txd;
        end
    end

    // ---------------- busy monitor ----------------
    logic b_prev = 1'b0;
    int   b_len  = 0;
    int   len_q[$];
    int   rise_q[$];

    always @(negedge clk) begin
        if (clr) begin
            b_len  = 0;
            b_prev = 1'b0;
        end else begin
            if (busy && !b_prev) rise_q.push_back(cyc);
            if (busy) b_len++;
            else if (b_prev) begin
                len_q.push_back(b_len);
                b_len = 0;
            end
            b_prev = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            step(1);
            n++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        req  = 1'b1;
        data = b;
        step(1);
        req = 1'b0;
        step(1);
        wait_idle(100);
    endtask

    logic [10:0] seq;
    logic        samp[45];
    int          bc, r0;
    logic [7:0]  exp_bytes[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        clr  = 1'b1;
        req  = 1'b0;
        data = 8'h00;
        step(3);
        chk("rst_txd", txd, 1'b1);
        chk("rst_ack", ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        clr = 1'b0;
        step(2);

        // Frame of 8'hA5, sampled mid-bit.
        req  = 1'b1;
        data = 8'hA5;
        step(1);
        chk("a5_ack_rise", ack, 1'b1);
        bc = 0;
        for (int c = 0; c < 45; c++) begin
            samp[c] = txd;
            if (busy) bc++;
            if (c == 1) req = 1'b0;
            step(1);
        end
`ifdef TX_PARITY_EN
        seq = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        seq = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
        for (int k = 0; k < NBITS; k++) chk("a5_bit", samp[k*CPB + 1], seq[k]);
        chk("a5_busy_cycles", bc, NBITS * CPB);

        // req held high: one frame only, ack held until req drops.
        r0   = rise_q.size();
        req  = 1'b1;
        data = 8'h3C;
        step(100);
        chk("hold_one_frame", rise_q.size() - r0, 1);
        chk("hold_ack_high", ack, 1'b1);
        req = 1'b0;
        step(1);
        chk("hold_ack_clear", ack, 1'b0);
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(1);
        wait_idle(100);
        chk("rearm_two_frames", rise_q.size() - r0, 2);

        // Early req drop and data change mid-frame.
        req  = 1'b1;
        data = 8'h3C;
        step(1);
        step(2);
        req = 1'b0;
        step(10);
        data = 8'hFF;
        step(5);
        chk("mid_ack_low", ack, 1'b0);
        chk("mid_busy_high", busy, 1'b1);
        wait_idle(100);

        // Async clear during data bit 3 of 8'h00.
        req  = 1'b1;
        data = 8'h00;
        step(1);
        req = 1'b0;
        step(16);
        chk("pre_clr_txd", txd, 1'b0);
        clr = 1'b1;
        #1;
        chk("clr_txd_async", txd, 1'b1);
        chk("clr_ack", ack, 1'b0);
        chk("clr_busy", busy, 1'b0);
        req  = 1'b1;
        data = 8'h5A;
        step(3);
        chk("clr_req_ignored", ack, 1'b0);
        clr = 1'b0;
        step(1);
        chk("post_clr_accept", ack, 1'b1);
        req = 1'b0;
        step(1);
        wait_idle(100);

        // Back-to-back 8'h01, 8'h80.
        req  = 1'b1;
        data = 8'h01;
        step(1);
        req = 1'b0;
        step(2);
        req  = 1'b1;
        data = 8'h80;
        wait_idle(100);
        step(1);
        req = 1'b0;
        step(1);
        wait_idle(100);
        chk("b2b_gap", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], NBITS * CPB + 1);

`ifdef TX_PARITY_EN
        send(8'h07);
        send(8'h03);
`endif
        step(4);

        exp_bytes = '{8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h5A, 8'h01, 8'h80};
`ifdef TX_PARITY_EN
        exp_bytes.push_back(8'h07);
        exp_bytes.push_back(8'h03);
`endif
        chk("frame_count", rx_q.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < rx_q.size(); i++)
            chk("rx_byte", rx_q[i], exp_bytes[i]);
        chk("len_count", len_q.size(), exp_bytes.size());
        for (int i = 0; i < len_q.size(); i++)
            chk("frame_len", len_q[i], NBITS * CPB);
`ifdef TX_PARITY_EN
        chk("par_count", par_q.size(), 9);
        if (par_q.size() == 9) begin
            chk("par_07", par_q[7], 1'b1);
            chk("par_03", par_q[8], 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
Serial UART transmitter, the sending end of the link our receiver terminates. Accepts one byte at a time from a local producer over a four-phase req/ack handshake. Serialises it on txd as an idle-high frame: start bit, 8 data bits LSB first, optional parity, stop bit. Sits between the host-side byte source and the board TX pin.

Parameters:
CLKS_PER_BIT, 580, clk cycles per serial bit; legal range 2..1023; 10-bit baud counter.
DATA_BITS, 8, data bits per frame; fixed at 8, not to be overridden.

Ports:
clk  input  1  system clock; all state changes on posedge.
clr  input  1  asynchronous, active-high reset.
req  input  1  producer request; data is valid and stable while req=1.
data  input  8  byte to send; sampled only on the accept edge.
ack  output  1  handshake acknowledge to the producer.
txd  output  1  serial line; 1 = idle/mark.
busy  output  1  1 while a frame is in flight (state != IDLE).

Behaviour:
- Reset (clr=1, async): txd=1, ack=0, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0. A frame in progress is abandoned immediately and txd returns high with no glitch low.
- All outputs are registered.
- States: IDLE, START, DATA, (PARITY), STOP.
- Accept: in IDLE with req=1 and ack=0 at posedge N:
  - shift_reg<=data, ack<=1, state<=START, txd<=0, baud counter<=0.
  - txd therefore falls in the cycle after N; busy rises with it.
- Baud timing: the counter runs 0..CLKS_PER_BIT-1. A bit ends when counter==CLKS_PER_BIT-1; the counter then wraps to 0. Every bit, including start and stop, is exactly CLKS_PER_BIT cycles.
- START -> DATA at end of bit: txd<=shift_reg[0].
- DATA: at each bit end, shift right and increment the bit index. After bit index 7 ends, go to PARITY if compiled in, else STOP with txd<=1.
- STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is 10*CLKS_PER_BIT cycles (11* with parity). Back-to-back frames: the next start bit may begin on the cycle after STOP ends.
- Handshake completion runs independently of the frame:
  - While ack=1, once req=0 is sampled, ack<=0 next cycle, in any state.
  - A new req is accepted only in IDLE with ack=0. A req held high through a whole frame is not re-accepted until it drops and ack clears (no double send).
- data changing after the accept edge has no effect on the frame in flight.
- req asserted during clr is ignored; after clr deasserts, it is accepted on the first edge where req=1 and state=IDLE.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: a PARITY state is inserted after data bit 7, lasting CLKS_PER_BIT cycles, with txd = XOR of the 8 data bits (even parity). Frame length is 11 bits.
- Undefined: no PARITY state, 10-bit frame, no parity logic synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - tx state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
  - DATA_BITS=8
  - default CLKS_PER_BIT=580
  - the IDLE_LEVEL=1 constant, also used by the receiver.
- One natural sub-module: uart_baud_gen. Inputs are clk, clr and a restart strobe; output is a one-cycle bit_end tick; CLKS_PER_BIT is a parameter. The receiver can reuse it later.

Test Plan:
- CLKS_PER_BIT=4; reset, then req=1 with data=8'hA5:
  - ack rises one cycle later.
  - txd sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for exactly 40 cycles.
- Hold req=1 for 100 cycles after an accept of data=8'h3C: exactly one frame sent. ack stays 1 until req drops, then clears next cycle. Drop req, re-raise it: a second frame is sent.
- Drop req 2 cycles after ack, then change data to 8'hFF mid-frame: the transmitted byte remains 8'h3C, and ack=0 while the frame continues.
- Assert clr during data bit 3 of 8'h00: txd=1 in the same cycle (async). ack=0, busy=0. A new req after release produces a full, clean frame.
- Two frames back-to-back (8'h01, 8'h80) with minimal handshake gaps: start of frame 2 is no earlier than the cycle after frame 1's 4-cycle stop bit.
- With TX_PARITY_EN defined, data=8'h07: parity bit=1, frame is 44 cycles. With data=8'h03: parity bit=0.
